// File: rtl/m72_pkg.sv
// Shared types and constants for the m72 SDRAM channel plumbing.
// Channel 3 is shared by the ROM loader, the CPU and an auxiliary client.
package m72_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_DONE  = 2'd2
   } arb_state_t;

   localparam int SDR_CH3_CLIENTS = 3;

   localparam int CH3_ROM = 0;
   localparam int CH3_CPU = 1;
   localparam int CH3_AUX = 2;

endpackage

// File: rtl/sdram_ch_arbiter_rr_select.sv
// Round-robin pick: the first set bit of eligible, searching upward from ptr
// and wrapping modulo NUM_CH (NUM_CH need not be a power of two).
module rr_select #(
   parameter int NUM_CH = 3,
   localparam int PTR_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [PTR_W-1:0]  ptr,
   output logic              valid,
   output logic [PTR_W-1:0]  index
);

   int k;

   always_comb begin
      valid = 1'b0;
      index = '0;
      k     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         k = int'(ptr) + i;
         if (k >= NUM_CH) k = k - NUM_CH;
         if (!valid && eligible[k]) begin
            valid = 1'b1;
            index = PTR_W'(k);
         end
      end
   end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// Registered round-robin arbiter multiplexing NUM_CH req/ready clients onto
// one SDRAM channel, with optional exclusive lock to a single client.
module sdram_ch_arbiter
   import m72_pkg::*;
#(
   parameter int NUM_CH    = SDR_CH3_CLIENTS,
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int RESET_PTR = 0,
   localparam int BE_W     = DATA_W / 8,
   localparam int PTR_W    = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   // Valid/ready: a requester holds req with a stable payload until its
   // one-cycle ready pulse, then drops req on the following cycle.
   input  logic [NUM_CH-1:0]        cl_req,
   input  logic [NUM_CH*ADDR_W-1:0] cl_addr,
   input  logic [NUM_CH*DATA_W-1:0] cl_din,
   input  logic [NUM_CH*BE_W-1:0]   cl_be,
   input  logic [NUM_CH-1:0]        cl_rnw,
   output logic [DATA_W-1:0]        cl_dout,
   output logic [NUM_CH-1:0]        cl_rdy,
   input  logic                     lock_en,
   input  logic [PTR_W-1:0]         lock_ch,
   output logic [ADDR_W-1:0]        sdr_addr,
   output logic [DATA_W-1:0]        sdr_din,
   output logic [BE_W-1:0]          sdr_be,
   output logic                     sdr_rnw,
   output logic                     sdr_req,
   input  logic                     sdr_rdy,
   input  logic [DATA_W-1:0]        sdr_dout,
   output logic                     busy,
   output logic [PTR_W-1:0]         grant_ch,
   output logic [1:0]               dbg_state,
   output logic [PTR_W-1:0]         dbg_rr_ptr
);

   arb_state_t          state_q,    state_d;
   logic [PTR_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [PTR_W-1:0]    grant_q,    grant_d;
   logic [ADDR_W-1:0]   sdr_addr_q, sdr_addr_d;
   logic [DATA_W-1:0]   sdr_din_q,  sdr_din_d;
   logic [BE_W-1:0]     sdr_be_q,   sdr_be_d;
   logic                sdr_rnw_q,  sdr_rnw_d;
   logic                sdr_req_q,  sdr_req_d;
   logic [NUM_CH-1:0]   cl_rdy_q,   cl_rdy_d;
   logic [DATA_W-1:0]   cl_dout_q,  cl_dout_d;

   logic [NUM_CH-1:0]   lock_mask;
   logic [NUM_CH-1:0]   eligible;
   logic                sel_valid;
   logic [PTR_W-1:0]    sel_idx;

   // An out-of-range lock_ch yields an empty mask, so nothing is eligible.
   always_comb begin
      lock_mask = '0;
      if (int'(lock_ch) < NUM_CH) lock_mask[lock_ch] = 1'b1;
      eligible = lock_en ? (cl_req & lock_mask) : cl_req;
   end

   rr_select #(.NUM_CH(NUM_CH)) u_rr_select (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .valid    (sel_valid),
      .index    (sel_idx)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      sdr_addr_d = sdr_addr_q;
      sdr_din_d  = sdr_din_q;
      sdr_be_d   = sdr_be_q;
      sdr_rnw_d  = sdr_rnw_q;
      sdr_req_d  = sdr_req_q;
      cl_dout_d  = cl_dout_q;
      cl_rdy_d   = '0;
      case (state_q)
         ARB_IDLE: begin
            if (sel_valid) begin
               sdr_addr_d = cl_addr[sel_idx*ADDR_W +: ADDR_W];
               sdr_din_d  = cl_din[sel_idx*DATA_W +: DATA_W];
               sdr_be_d   = cl_be[sel_idx*BE_W +: BE_W];
               sdr_rnw_d  = cl_rnw[sel_idx];
               grant_d    = sel_idx;
               sdr_req_d  = 1'b1;
               state_d    = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (sdr_rdy) begin
               sdr_req_d = 1'b0;
               if (sdr_rnw_q) cl_dout_d = sdr_dout;
               cl_rdy_d[grant_q] = 1'b1;
               if (grant_q == PTR_W'(NUM_CH - 1)) rr_ptr_d = '0;
               else                               rr_ptr_d = grant_q + 1'b1;
               state_d = ARB_DONE;
            end
         end
         // One dead cycle so the finished client's req has dropped before
         // the next arbitration looks at it.
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= PTR_W'(RESET_PTR);
         grant_q    <= '0;
         sdr_addr_q <= '0;
         sdr_din_q  <= '0;
         sdr_be_q   <= '0;
         sdr_rnw_q  <= 1'b1;
         sdr_req_q  <= 1'b0;
         cl_rdy_q   <= '0;
         cl_dout_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         sdr_addr_q <= sdr_addr_d;
         sdr_din_q  <= sdr_din_d;
         sdr_be_q   <= sdr_be_d;
         sdr_rnw_q  <= sdr_rnw_d;
         sdr_req_q  <= sdr_req_d;
         cl_rdy_q   <= cl_rdy_d;
         cl_dout_q  <= cl_dout_d;
      end
   end

   assign sdr_addr   = sdr_addr_q;
   assign sdr_din    = sdr_din_q;
   assign sdr_be     = sdr_be_q;
   assign sdr_rnw    = sdr_rnw_q;
   assign sdr_req    = sdr_req_q;
   assign cl_rdy     = cl_rdy_q;
   assign cl_dout    = cl_dout_q;
   assign grant_ch   = grant_q;
   assign busy       = (state_q != ARB_IDLE);
   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: doc/sdram_ch_arbiter.md
Name: sdram_ch_arbiter

Overview:
- Parametrised N-client arbiter that multiplexes several req/ready masters onto one SDRAM channel (e.g. ch3: ROM loader, CPU, future sample/NVRAM clients).
- Replaces the fixed two-way combinational ROM-download/CPU mux with registered round-robin arbitration, optional exclusive channel lock, per-client read-data return and single-cycle ready pulses.
- Sits between the clients and the sdram controller, in the SDRAM clock domain.

Parameters:
- NUM_CH, 3, number of clients (2..8, need not be a power of two)
- ADDR_W, 24, word-address width (address bits [ADDR_W:1])
- DATA_W, 16, data width; BE_W = DATA_W/8 derived locally
- RESET_PTR, 0, round-robin pointer value after reset

Ports:
- clk  in  1  SDRAM-domain clock
- reset  in  1  synchronous, active-high
- cl_req  in  NUM_CH  per-client request level
- cl_addr  in  NUM_CH*ADDR_W  client addresses, client i at slice i
- cl_din  in  NUM_CH*DATA_W  client write data
- cl_be  in  NUM_CH*BE_W  client byte enables
- cl_rnw  in  NUM_CH  1=read, 0=write
- cl_dout  out  DATA_W  read data from last completed read (shared bus)
- cl_rdy  out  NUM_CH  one-cycle completion pulse per client
- lock_en  in  1  restrict arbitration to lock_ch only
- lock_ch  in  $clog2(NUM_CH)  client allowed while lock_en=1
- sdr_addr  out  ADDR_W  registered address to sdram
- sdr_din  out  DATA_W  registered write data
- sdr_be  out  BE_W  registered byte enables
- sdr_rnw  out  1  registered read/not-write
- sdr_req  out  1  request level to sdram
- sdr_rdy  in  1  sdram completion pulse
- sdr_dout  in  DATA_W  sdram read data, valid with sdr_rdy
- busy  out  1  transaction in flight (state != IDLE)
- grant_ch  out  $clog2(NUM_CH)  client owning current/last transaction

Behaviour:
- Handshake (client and sdram side): requester holds req high with payload stable until ready pulses for one cycle; requester must then drop req the following cycle.
- Reset: state=IDLE; sdr_req=0, cl_rdy=0, cl_dout=0, sdr_addr/din/be=0, sdr_rnw=1, busy=0, grant_ch=0, rr_ptr=RESET_PTR.
- FSM IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: eligible = lock_en ? (cl_req & onehot(lock_ch)) : cl_req. If any eligible, pick the first eligible index searching upward from rr_ptr, wrapping modulo NUM_CH. Latch that client's payload into the sdr_* registers, set grant_ch, sdr_req<=1, go to ISSUE.
- ISSUE: hold sdr_req and payload. On sdr_rdy: sdr_req<=0; cl_dout<=sdr_dout if sdr_rnw, else unchanged; cl_rdy[grant_ch]<=1 for exactly one cycle; rr_ptr<=(grant_ch+1) mod NUM_CH; go to DONE.
- DONE: cl_rdy cleared; always return to IDLE. The extra cycle lets the client drop req so a stale req cannot be re-granted.
- Latency: client req seen at cycle 0 -> sdr_req high at cycle 1; sdr_rdy at cycle k -> cl_rdy high at k+1; next grant's sdr_req high at k+3 at the earliest.
- lock_en/lock_ch are sampled only in IDLE. An in-flight transaction for another client always completes.
- lock_ch >= NUM_CH with lock_en=1: no client is eligible and the block stays IDLE.
- A client deasserting req while granted is a protocol violation. The transaction still completes and cl_rdy still pulses.
- sdr_rdy in IDLE or DONE is ignored.
- Simultaneous requests: exactly one grant per arbitration; losers wait, and their payload is not sampled.
- Reset mid-transaction: sdr_req drops the next cycle; no cl_rdy is generated; the sdram controller must tolerate a dropped request.

Decomposition:
- m72_pkg gains typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_DONE}, plus localparam SDR_CH3_CLIENTS and named client indices (CH3_ROM=0, CH3_CPU=1, CH3_AUX=2).
- One combinational sub-module, rr_select: inputs NUM_CH-bit eligible and rr_ptr; outputs valid and index, wrap-around search, non-power-of-two safe.

Test Plan:
- Single read: cl_req[1]=1, addr=24'h000123, sdr_rdy at cycle 4 with dout=16'hBEEF -> sdr_req high cycles 1-4, sdr_addr=24'h000123, cl_rdy[1] pulses at cycle 5, cl_dout=16'hBEEF, rr_ptr=2.
- Round-robin fairness: all three clients request continuously, sdr_rdy 2 cycles after each sdr_req -> grant order 0,1,2,0,1,2; each cl_rdy pulses exactly once per grant.
- Lock: lock_en=1, lock_ch=0, clients 0 and 1 requesting, 20 transactions -> only client 0 is granted. Dropping lock_en -> client 1 is granted next.
- Write: client 2 with rnw=0, din=16'h55AA, be=2'b01 -> sdr_rnw=0, sdr_be=2'b01, sdr_din=16'h55AA; cl_dout unchanged from its prior value.
- Reset mid-ISSUE: assert reset one cycle while sdr_req=1 -> all outputs return to reset values next cycle; no cl_rdy pulse; a following request is serviced normally.
- NUM_CH=5 wrap: rr_ptr=4, requests on clients 1 and 3 -> client 1 is granted first, then client 3.
